booth_mul_param: RTL
====================

# booth_mul_param

Parametrised radix-4 Booth sequential multiplier: successor to the fixed 64-bit multiplier core, generalised to any even operand width and to a signed/unsigned mode. Serves as the multiply unit behind the datapath's op_start/op_clear/op_done command handshake. Fixed iteration count, registered result held until cleared or restarted, plus an explicit busy indication.

## Interface
- WIDTH, default 64: operand width in bits; even, >= 4.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- op_start  input  1  start request; sampled only in IDLE or DONE.
- op_clear  input  1  synchronous clear; returns the block to IDLE.
- signed_mode  input  1  1: operands are two's complement; 0: operands are unsigned. Sampled with op_start.
- multiplicand  input  WIDTH  operand A; sampled with op_start.
- multiplier  input  WIDTH  operand B; sampled with op_start.
- busy  output  1  high while iterating.
- op_done  output  1  high in DONE; result valid.
- result  output  2*WIDTH  product; registered.
- ovf  output  1  product does not fit in WIDTH bits (BOOTH_MUL_OVF_EN only).

## Operation
- States: IDLE, BUSY, DONE. Reset -> IDLE; busy=0, op_done=0, result=0, ovf=0, all internal registers 0.
- Priority per edge: reset > op_clear > op_start > iteration.
- op_clear (any state): -> IDLE, result=0, op_done=0, busy=0, ovf=0, iteration counter 0. op_clear and op_start together: clear wins, start dropped.
- op_start in IDLE or DONE: load operands extended to WIDTH+2 bits (sign-extend if signed_mode, zero-extend otherwise), accumulator 0, Booth prior bit 0, counter 0, op_done=0 -> BUSY. result keeps previous value until completion.
- op_start in BUSY: ignored.
- BUSY, each edge: recode {B[1],B[0],prior} into {0, +M, +2M, -M, -2M}; add to accumulator; arithmetic shift {acc, B, prior} right by 2; counter+1.
- Accumulator WIDTH+4 bits, sign-extended so +/-2M never overflows. Negation = two's complement of M.
- Iteration count N = WIDTH/2 + 1 for both modes (extra 2 bits make unsigned operands positive).
- After iteration N: result = low 2*WIDTH bits of {acc, B}; op_done=1; busy=0 -> DONE. Remain in DONE, all outputs held, until op_clear or op_start.
- Out-of-range recode codes do not exist (3-bit code fully decoded); no X generation.

## Timing
- Start accepted at edge E: busy=1 after E; iterations on edges E+1..E+N; op_done=1 and result updated after edge E+N. Latency N cycles (33 for WIDTH=64, 5 for WIDTH=8).
- Back-to-back: op_start held in DONE restarts on the same edge op_done is observed; op_done drops after that edge.
- Reset mid-operation: immediate return to reset values, asynchronously.
- op_clear mid-operation: aborts, takes effect at the next edge.

## Configuration
- BOOTH_MUL_OVF_EN defined: ovf port present; set with op_done when signed_mode and result is not the sign extension of result[WIDTH-1:0], or unsigned and result[2*WIDTH-1:WIDTH] != 0; held in DONE, cleared by start/clear/reset.
- Undefined: no ovf port, no overflow logic.

## Structure
- Package booth_mul_pkg: state enum (IDLE, BUSY, DONE), Booth operation enum (ZERO, ADD_M, ADD_2M, SUB_M, SUB_2M), iteration-count function of WIDTH.
- Sub-module booth_recoder: combinational 3-bit code -> Booth operation enum; shared by future radix-4 datapaths.

## Test plan
- WIDTH=8, signed, -128 * -128 -> result 0x4000, op_done exactly 5 cycles after start edge, busy high for those 5 cycles.
- WIDTH=8, unsigned, 255 * 255 -> result 0xFE01; same operands signed -> 0x0001.
- WIDTH=64, signed, 0x7FFF_FFFF_FFFF_FFFF * -1 -> 0xFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001 after 33 cycles.
- op_start pulsed at cycle 2 of BUSY with new operands -> ignored, original product delivered; op_clear at cycle 3 of a second operation -> result 0, op_done 0 next cycle; following start works normally.
- reset asserted mid-BUSY -> all outputs 0 immediately; op_start together with op_clear in DONE -> IDLE, result 0.
- BOOTH_MUL_OVF_EN, WIDTH=8: signed 16*8 -> ovf=1; signed 15*8 -> ovf=0; unsigned 16*16 -> ovf=1; unsigned 15*17 -> ovf=0.

Source files
------------

// File: rtl/booth_mul_pkg.sv
// rtl/booth_mul_pkg.sv - shared types and sizing helpers for the radix-4 Booth multiplier
//
// Contents:
//   state_e    : sequencer states (IDLE, BUSY, DONE)
//   booth_op_e : radix-4 Booth partial-product selection (ZERO, +M, +2M, -M, -2M)
//   iter_count : number of Booth iterations for a given operand width
//   cnt_width  : width of a counter that can hold 0..iter_count(width)
package booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        ADD_M  = 3'd1,
        ADD_2M = 3'd2,
        SUB_M  = 3'd3,
        SUB_2M = 3'd4
    } booth_op_e;

    // Operands are widened by two bits before recoding so that unsigned
    // values stay positive; that costs one extra radix-4 step.
    function automatic int iter_count(input int width);
        return width / 2 + 1;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(iter_count(width) + 1);
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// rtl/booth_recoder.sv - combinational radix-4 Booth digit recoder
//
// Ports:
//   code_i : {b[1], b[0], prior} window of the multiplier
//   op_o   : selected partial-product operation
// Every 3-bit code is decoded, so the output is never undefined.
module booth_recoder
    import booth_mul_pkg::*;
(
    input  logic [2:0] code_i,
    output booth_op_e  op_o
);

    always_comb begin
        op_o = ZERO;
        case (code_i)
            3'b000, 3'b111: op_o = ZERO;
            3'b001, 3'b010: op_o = ADD_M;
            3'b011:         op_o = ADD_2M;
            3'b100:         op_o = SUB_2M;
            3'b101, 3'b110: op_o = SUB_M;
            default:        op_o = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mul_param.sv
// rtl/booth_mul_param.sv - parametrised radix-4 Booth sequential multiplier
//
// Optional feature macro: BOOTH_MUL_OVF_EN (adds the ovf output and its logic).
//
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous active-high reset
//   op_start     : start request, honoured in IDLE or DONE
//   op_clear     : synchronous clear back to IDLE (wins over op_start)
//   signed_mode  : 1 = two's complement operands, 0 = unsigned; sampled with op_start
//   multiplicand : operand A, sampled with op_start
//   multiplier   : operand B, sampled with op_start
//   busy         : high while iterating
//   op_done      : high in DONE, result valid
//   result       : registered 2*WIDTH-bit product
//   ovf          : product does not fit in WIDTH bits (BOOTH_MUL_OVF_EN only)
module booth_mul_param
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               op_done,
    output logic [2*WIDTH-1:0] result
`ifdef BOOTH_MUL_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int ITER = iter_count(WIDTH);
    localparam int CW   = cnt_width(WIDTH);
    localparam int BW   = WIDTH + 2;   // extended operand width
    localparam int AW   = WIDTH + 4;   // accumulator width, headroom for +/-2M
    localparam int PW   = 2 * WIDTH;   // product width
    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   m_q, m_d;
    logic [BW-1:0]   b_q, b_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            prior_q, prior_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   result_q, result_d;
`ifdef BOOTH_MUL_OVF_EN
    logic            sgn_q, sgn_d;
    logic            ovf_q, ovf_d;
    logic            ovf_calc;
`endif

    booth_op_e       op;
    logic [AW-1:0]   m_ext;
    logic [AW-1:0]   m2_ext;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   iter_acc;
    logic [BW-1:0]   iter_b;
    logic [PW-1:0]   product_next;

    function automatic logic [BW-1:0] extend(input logic [WIDTH-1:0] x, input logic sgn);
        return {{2{sgn & x[WIDTH-1]}}, x};
    endfunction

    booth_recoder u_recoder (
        .code_i ({b_q[1:0], prior_q}),
        .op_o   (op)
    );

    // Multiplicand sits at the top of {acc, B}; sign-extend into the
    // accumulator so that 2M and -2M stay representable.
    assign m_ext  = {{2{m_q[BW-1]}}, m_q};
    assign m2_ext = {m_q[BW-1], m_q, 1'b0};

    always_comb begin
        addend = '0;
        case (op)
            ADD_M:   addend = m_ext;
            ADD_2M:  addend = m2_ext;
            SUB_M:   addend = ~m_ext + AW'(1);
            SUB_2M:  addend = ~m2_ext + AW'(1);
            default: addend = '0;
        endcase
    end

    assign sum = acc_q + addend;

    // Arithmetic shift of {acc, B, prior} right by two.
    assign iter_acc     = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign iter_b       = {sum[1:0], b_q[BW-1:2]};
    assign product_next = {iter_acc[WIDTH-3:0], iter_b};

`ifdef BOOTH_MUL_OVF_EN
    always_comb begin
        if (sgn_q) begin
            ovf_calc = product_next[PW-1:WIDTH] != {WIDTH{product_next[WIDTH-1]}};
        end else begin
            ovf_calc = product_next[PW-1:WIDTH] != '0;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        b_d      = b_q;
        acc_d    = acc_q;
        prior_d  = prior_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef BOOTH_MUL_OVF_EN
        sgn_d    = sgn_q;
        ovf_d    = ovf_q;
`endif
        if (op_clear) begin
            state_d  = IDLE;
            result_d = '0;
            cnt_d    = '0;
`ifdef BOOTH_MUL_OVF_EN
            ovf_d    = 1'b0;
`endif
        end else if (op_start && (state_q != BUSY)) begin
            state_d = BUSY;
            m_d     = extend(multiplicand, signed_mode);
            b_d     = extend(multiplier, signed_mode);
            acc_d   = '0;
            prior_d = 1'b0;
            cnt_d   = '0;
`ifdef BOOTH_MUL_OVF_EN
            sgn_d   = signed_mode;
            ovf_d   = 1'b0;
`endif
        end else if (state_q == BUSY) begin
            acc_d   = iter_acc;
            b_d     = iter_b;
            prior_d = b_q[1];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
                state_d  = DONE;
                result_d = product_next;
`ifdef BOOTH_MUL_OVF_EN
                ovf_d    = ovf_calc;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            m_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            prior_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef BOOTH_MUL_OVF_EN
            sgn_q    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            prior_q  <= prior_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
`ifdef BOOTH_MUL_OVF_EN
            sgn_q    <= sgn_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy    = (state_q == BUSY);
    assign op_done = (state_q == DONE);
    assign result  = result_q;
`ifdef BOOTH_MUL_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule
